forward_scoreboard: RTL
=======================

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, number of in-flight stages tracked (EX, MEM, WB), legal range 1..7.
REQ-003 Parameter SEL_WIDTH, default 2, select width, SHALL satisfy 2**SEL_WIDTH >= DEPTH+1.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 id_valid  input  1  instruction present in decode.
REQ-007 id_rs1, id_rs2  input  ADDR_WIDTH  decode source registers.
REQ-008 id_rd  input  ADDR_WIDTH  decode destination register.
REQ-009 id_we  input  1  decode instruction writes id_rd.
REQ-010 id_is_load  input  1  decode instruction is a load.
REQ-011 flush  input  1  kill decode instruction and stage-0 entry.
REQ-012 op1_select, op2_select  output  SEL_WIDTH  0 = register file, k = forward from stage k-1.
REQ-013 stall  output  1  load-use hazard, hold fetch/decode.
REQ-014 stall_count  output  16  saturating stall-cycle count (see Configuration).

Function
REQ-015 Block SHALL hold DEPTH entries {valid, rd, we, is_load}; entry 0 = youngest (EX).
REQ-016 Each clock, entries k>=1 SHALL load entry k-1; entry DEPTH-1 content retires.
REQ-017 Entry 0 SHALL load the decode instruction when id_valid=1, stall=0, flush=0; otherwise a bubble (valid=0).
REQ-018 flush=1 SHALL additionally invalidate entry-0 content before it shifts, i.e. entry 1 receives a bubble that cycle.
REQ-019 An entry matches source s when valid=1, we=1, rd!=0, rd==s.
REQ-020 op1_select SHALL be k+1 for the lowest-index matching entry k against id_rs1; 0 when none matches or id_rs1==0.
REQ-021 op2_select SHALL follow REQ-020 against id_rs2.
REQ-022 Selects SHALL be combinational from current entries and decode inputs: zero-cycle latency, youngest producer wins.
REQ-023 stall SHALL be 1 when id_valid=1, flush=0, and entry 0 is a matching load for id_rs1 or id_rs2; otherwise 0.
REQ-024 During stall, decode inputs are held by upstream; a single stall cycle SHALL clear the hazard (load moves to entry 1, select=2).
REQ-025 id_we=0 or id_rd=0 instructions SHALL enter the scoreboard but never match.
REQ-026 Decode rd equal to its own rs SHALL not self-match (decode is not yet in entry 0).

Reset
REQ-027 rst=1 at a clock edge SHALL clear all entry valid bits and stall_count, overriding flush and insertion.
REQ-028 While entries are invalid after reset: op1_select=0, op2_select=0, stall=0.
REQ-029 Reset mid-stall SHALL drop the pending load; next cycle stall=0.

Configuration
REQ-030 Macro FWD_STALL_COUNT_EN defined: stall_count SHALL increment by 1 each clock with stall=1, saturating at 16'hFFFF.
REQ-031 Macro undefined: stall_count SHALL be constant 0 and counter logic absent.

Verification
REQ-032 Reset, then idle -> selects 0, stall 0, stall_count 0.
REQ-033 Issue add x5 (we=1), next cycle decode rs1=5, rs2=5 -> op1_select=1, op2_select=1, stall=0; one cycle later with rs1=5 -> 2; then 3; then 0.
REQ-034 Issue x7 writers on consecutive cycles, decode rs1=7 -> select=1 (youngest wins over 2).
REQ-035 Load to x9, next decode rs2=9 -> stall=1 for exactly one cycle, then op2_select=2; stall_count=1 with macro, 0 without.
REQ-036 Writer to x0 and writer with we=0 to x3, decode rs1=0, rs2=3 -> both selects 0.
REQ-037 Load to x4 with flush=1 same cycle, decode rs1=4 next -> stall=0, select 0; rst asserted during a stall -> stall=0 next cycle.

Source files
------------

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight writers and produces operand selects and a load-use stall.
// Define FWD_STALL_COUNT_EN to enable the saturating stall_count counter; otherwise stall_count is tied to 0.
module forward_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 3,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic                  id_we,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [SEL_WIDTH-1:0]  op1_select,
  output logic [SEL_WIDTH-1:0]  op2_select,
  output logic                  stall,
  output logic [15:0]           stall_count
);

  localparam int RD_BITS = DEPTH * ADDR_WIDTH;

  logic [DEPTH-1:0]   ent_valid;
  logic [DEPTH-1:0]   ent_we;
  logic [DEPTH-1:0]   ent_load;
  logic [RD_BITS-1:0] ent_rd;

  logic [DEPTH-1:0]   hit_rs1;
  logic [DEPTH-1:0]   hit_rs2;
  logic [DEPTH-1:0]   valid_src;
  logic               insert;

  always_comb begin
    logic [ADDR_WIDTH-1:0] rd_k;
    rd_k    = '0;
    hit_rs1 = '0;
    hit_rs2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_k       = ent_rd[k*ADDR_WIDTH +: ADDR_WIDTH];
      hit_rs1[k] = ent_valid[k] & ent_we[k] & (rd_k != '0) & (rd_k == id_rs1);
      hit_rs2[k] = ent_valid[k] & ent_we[k] & (rd_k != '0) & (rd_k == id_rs2);
    end
  end

  // Scan oldest to youngest so the youngest matching producer overwrites last.
  always_comb begin
    op1_select = '0;
    op2_select = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_rs1[k]) op1_select = SEL_WIDTH'(k + 1);
      if (hit_rs2[k]) op2_select = SEL_WIDTH'(k + 1);
    end
  end

  assign stall  = id_valid & ~flush & ent_load[0] & (hit_rs1[0] | hit_rs2[0]);
  assign insert = id_valid & ~stall & ~flush;

  always_comb begin
    valid_src    = ent_valid;
    valid_src[0] = ent_valid[0] & ~flush;
  end

  // Shift toward higher indices; the new entry lands at index 0 and the oldest drops off the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      ent_we    <= '0;
      ent_load  <= '0;
      ent_rd    <= '0;
    end else begin
      ent_valid <= DEPTH'({valid_src, insert});
      ent_we    <= DEPTH'({ent_we, id_we});
      ent_load  <= DEPTH'({ent_load, id_is_load});
      ent_rd    <= RD_BITS'({ent_rd, id_rd});
    end
  end

`ifdef FWD_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule
